gb_instr_sequencer: RTL and testbench
=====================================

GB_INSTR_SEQUENCER -- requirements
Module: gb_instr_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction queue entries (power of two, 2..16).
REQ-002 SHALL have parameter GAP, default 1, idle cycles forced after each issue (0..15).
REQ-003 SHALL have port clock  input  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  requester offers an opcode.
REQ-006 SHALL have port in_instr  input  8  offered opcode.
REQ-007 SHALL have port in_ready  output  1  queue can accept this cycle.
REQ-008 SHALL have port resume  input  1  single-cycle pulse releasing the HALT state.
REQ-009 SHALL have port instruction  output  8  opcode to the gbprocessor datapath.
REQ-010 SHALL have port valid  output  1  instruction is valid to the datapath.
REQ-011 SHALL have port busy  output  1  queue non-empty or FSM not in IDLE.
REQ-012 SHALL have port halted  output  1  FSM in HALT.

Function
REQ-013 SHALL accept in_instr into the queue tail on each rising edge with in_valid=1 and in_ready=1.
REQ-014 SHALL drive in_ready = queue not full, independent of any pop in the same cycle.
REQ-015 SHALL ignore in_valid while in_ready=0; the offered opcode is not stored.
REQ-016 SHALL implement FSM states IDLE, ISSUE, GAP, HALT.
REQ-017 IDLE: SHALL go to ISSUE on the next edge when the queue is non-empty.
REQ-018 ISSUE: SHALL pop the head and register it onto instruction with valid=1 for exactly one cycle.
REQ-019 From ISSUE: SHALL go to HALT if the popped opcode is 8'h76; else to GAP if GAP>0; else stay in ISSUE if the queue is still non-empty; else go to IDLE.
REQ-020 GAP: SHALL hold valid=0 for exactly GAP cycles, then go to ISSUE if the queue is non-empty, else to IDLE.
REQ-021 HALT: SHALL hold valid=0 and keep accepting pushes; on resume=1 go to IDLE on the next edge; resume outside HALT is ignored.
REQ-022 SHALL drive instruction=8'h00 whenever valid=0.
REQ-023 Latency: opcode pushed at edge k into an empty queue with the FSM in IDLE SHALL appear with valid=1 in the cycle after edge k+2.
REQ-024 SHALL preserve FIFO order; no opcode is dropped or duplicated.

Reset
REQ-025 reset=1 SHALL, at the next edge: empty the queue, set FSM=IDLE, valid=0, instruction=8'h00, halted=0, busy=0, in_ready=1.
REQ-026 Reset mid-ISSUE, mid-GAP or mid-HALT SHALL discard queued opcodes and the GAP count; no valid pulse SHALL follow from pre-reset contents.

Configuration
REQ-027 With macro GB_SEQ_STATS_EN defined: SHALL add output issue_count (16 bits), +1 per valid pulse, wrapping 16'hFFFF->16'h0000, reset to 0.
REQ-028 Without GB_SEQ_STATS_EN: port issue_count and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package gb_seq_pkg SHALL hold the FSM state enum typedef, the constant HALT_OPCODE=8'h76, and the DEPTH/GAP defaults.
REQ-030 The queue SHALL be a sub-module gb_seq_fifo (parameter DEPTH, push/pop/full/empty, synchronous reset).

Verification
REQ-031 Reset 5 cycles, push 8'h8C once (GAP=1) -> single valid pulse carrying 8'h8C two cycles after the push; busy then returns to 0.
REQ-032 Push 8'h80,8'h81,8'h82 back-to-back (GAP=1) -> valid pulses in order, exactly one idle cycle between them; with GAP=0, three consecutive valid cycles.
REQ-033 Hold in_valid=1 with DEPTH=4 while the FSM is in HALT -> in_ready falls after 4 accepts; the 5th opcode is not stored.
REQ-034 Push 8'h76 then 8'h04 -> 8'h76 is issued, halted=1, no issue of 8'h04 until a resume pulse; 8'h04 issues after resume.
REQ-035 Assert reset during GAP with 3 entries queued -> no further valid pulses; valid=0, instruction=8'h00, busy=0 after the reset edge.
REQ-036 With GB_SEQ_STATS_EN, sweep opcodes 8'h00..8'hFE skipping 8'h76 (254 issues) -> issue_count=254; force wrap from 16'hFFFF -> 16'h0000.

Source files
------------

// File: rtl/gb_seq_pkg.sv
// Shared definitions for the gb_instr_sequencer block.
//   seq_state_e   : sequencer FSM states (IDLE, ISSUE, GAP, HALT)
//   HALT_OPCODE   : opcode that parks the sequencer in HALT once issued
//   DEPTH_DEFAULT : default instruction queue depth
//   GAP_DEFAULT   : default number of idle cycles forced after each issue
package gb_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_e;

  localparam int         INSTR_W       = 8;
  localparam logic [7:0] HALT_OPCODE   = 8'h76;
  localparam int         DEPTH_DEFAULT = 4;
  localparam int         GAP_DEFAULT   = 1;

endpackage

// File: rtl/gb_seq_fifo.sv
// Instruction queue for the sequencer: a DEPTH-entry circular buffer.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset, empties the queue
//   push_i  : write data_i at the tail (ignored when full)
//   data_i  : opcode to enqueue
//   pop_i   : drop the head entry (ignored when empty)
//   head_o  : current head entry (undefined when empty)
//   full_o  : queue holds DEPTH entries
//   empty_o : queue holds no entries
//   count_o : current occupancy
module gb_seq_fifo
  import gb_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int W     = INSTR_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Fullness is judged on the current occupancy only, so a pop in the
  // same cycle never opens room for a push.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is data only; stale entries are unreachable after reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/gb_instr_sequencer.sv
// Instruction sequencer feeding the gbprocessor datapath. Opcodes are queued
// and issued one per ISSUE cycle as a registered single-cycle valid pulse,
// followed by GAP forced idle cycles. Issuing HALT_OPCODE parks the FSM in
// HALT until a resume pulse.
// Optional feature: define GB_SEQ_STATS_EN to add the 16-bit issue_count
// output (wrapping count of valid pulses).
// Ports:
//   clock       : clock, rising edge
//   reset       : synchronous active-high reset
//   in_valid    : requester offers in_instr
//   in_instr    : offered opcode
//   in_ready    : queue not full (accept happens when in_valid && in_ready)
//   resume      : single-cycle pulse releasing HALT
//   instruction : issued opcode, 8'h00 whenever valid=0
//   valid       : instruction valid to the datapath
//   busy        : queue non-empty or FSM not IDLE
//   halted      : FSM in HALT
//   issue_count : (GB_SEQ_STATS_EN only) number of valid pulses, mod 2^16
module gb_instr_sequencer
  import gb_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int GAP   = GAP_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_instr,
  output logic        in_ready,
  input  logic        resume,
  output logic [7:0]  instruction,
  output logic        valid,
  output logic        busy,
  output logic        halted
`ifdef GB_SEQ_STATS_EN
  ,
  output logic [15:0] issue_count
`endif
);

  localparam int         CW       = $clog2(DEPTH) + 1;
  // GAP state is left when the counter reaches zero, so load GAP-1.
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  seq_state_e    state_q, state_d;
  logic [3:0]    gap_cnt_q, gap_cnt_d;
  logic          valid_q, valid_d;
  logic [7:0]    instr_q, instr_d;

  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  gb_seq_fifo #(
    .DEPTH (DEPTH),
    .W     (INSTR_W)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (in_valid),
    .data_i  (in_instr),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // State register plus the registered issue outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= 4'd0;
      valid_q   <= 1'b0;
      instr_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
    end
  end

  // Next-state logic; "queue still non-empty" after an ISSUE pop means more
  // than one entry was present, same-cycle pushes are seen on the next pass.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (fifo_head == HALT_OPCODE) begin
          state_d = ST_HALT;
        end else if (GAP > 0) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
        end else if (fifo_count > CW'(1)) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = fifo_empty ? ST_IDLE : ST_ISSUE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      ST_HALT: begin
        if (resume) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: ISSUE pops the head and stages it for the output register
  always_comb begin
    fifo_pop = 1'b0;
    valid_d  = 1'b0;
    instr_d  = 8'h00;
    if (state_q == ST_ISSUE) begin
      fifo_pop = 1'b1;
      valid_d  = 1'b1;
      instr_d  = fifo_head;
    end
  end

  assign in_ready    = !fifo_full;
  assign instruction = instr_q;
  assign valid       = valid_q;
  assign busy        = !fifo_empty || (state_q != ST_IDLE);
  assign halted      = (state_q == ST_HALT);

`ifdef GB_SEQ_STATS_EN
  logic [15:0] issue_cnt_q;

  // Counts at the edge that launches each valid pulse; wraps freely.
  always_ff @(posedge clock) begin
    if (reset) begin
      issue_cnt_q <= 16'h0000;
    end else if (valid_d) begin
      issue_cnt_q <= issue_cnt_q + 16'd1;
    end
  end

  assign issue_count = issue_cnt_q;
`endif

endmodule

// File: tb/tb_gb_instr_sequencer.sv
// Bench for gb_instr_sequencer: two instances (GAP=0 and GAP=1, DEPTH=4)
// share one stimulus stream; each has its own queue-based reference model.
module tb_gb_instr_sequencer;

  localparam int DEPTH   = 4;
  localparam int S_IDLE  = 0;
  localparam int S_ISSUE = 1;
  localparam int S_GAP   = 2;
  localparam int S_HALT  = 3;
  localparam int GAPV [2] = '{0, 1};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset    = 1'b1;
  logic       in_valid = 1'b0;
  logic       resume   = 1'b0;
  logic [7:0] in_instr = 8'h00;

  logic [1:0]      rdy_w, valid_w, busy_w, halted_w;
  logic [1:0][7:0] instr_w;
`ifdef GB_SEQ_STATS_EN
  logic [1:0][15:0] cnt_w;
`endif

  int checks   = 0;
  int failures = 0;

  gb_instr_sequencer #(.DEPTH(DEPTH), .GAP(0)) dut0 (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (rdy_w[0]),
    .resume      (resume),
    .instruction (instr_w[0]),
    .valid       (valid_w[0]),
    .busy        (busy_w[0]),
    .halted      (halted_w[0])
`ifdef GB_SEQ_STATS_EN
    ,
    .issue_count (cnt_w[0])
`endif
  );

  gb_instr_sequencer #(.DEPTH(DEPTH), .GAP(1)) dut1 (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (rdy_w[1]),
    .resume      (resume),
    .instruction (instr_w[1]),
    .valid       (valid_w[1]),
    .busy        (busy_w[1]),
    .halted      (halted_w[1])
`ifdef GB_SEQ_STATS_EN
    ,
    .issue_count (cnt_w[1])
`endif
  );

  // Reference model: queue contents, phase, remaining gap cycles and the
  // output values expected after the most recent edge.
  logic [7:0]  mq [2][$];
  int          mst [2];
  int          mleft [2];
  logic        mvalid [2];
  logic [7:0]  minstr [2];
  logic [15:0] mcnt [2];

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      logic [7:0] op;
      bit         acc;
      acc = in_valid && (mq[m].size() < DEPTH);
      if (reset) begin
        mq[m].delete();
        mst[m]    = S_IDLE;
        mleft[m]  = 0;
        mvalid[m] = 1'b0;
        minstr[m] = 8'h00;
        mcnt[m]   = 16'h0000;
      end else begin
        mvalid[m] = 1'b0;
        minstr[m] = 8'h00;
        case (mst[m])
          S_IDLE: if (mq[m].size() > 0) mst[m] = S_ISSUE;
          S_ISSUE: begin
            op        = mq[m].pop_front();
            mvalid[m] = 1'b1;
            minstr[m] = op;
            mcnt[m]   = mcnt[m] + 16'd1;
            if (op == 8'h76) mst[m] = S_HALT;
            else if (GAPV[m] > 0) begin
              mst[m]   = S_GAP;
              mleft[m] = GAPV[m];
            end else mst[m] = (mq[m].size() > 0) ? S_ISSUE : S_IDLE;
          end
          S_GAP: begin
            mleft[m] = mleft[m] - 1;
            if (mleft[m] == 0) mst[m] = (mq[m].size() > 0) ? S_ISSUE : S_IDLE;
          end
          default: if (resume) mst[m] = S_IDLE;
        endcase
        if (acc) mq[m].push_back(in_instr);
      end
    end
  endtask

  // Advance one clock; outputs are then sampled at the falling edge.
  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; resume = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ({rdy_w[m], valid_w[m], instr_w[m], busy_w[m], halted_w[m]} !== 12'b1_0_00000000_0_0) begin
        failures++;
        $display("FAIL reset_state dut%0d got=%b want=%b", m,
                 {rdy_w[m], valid_w[m], instr_w[m], busy_w[m], halted_w[m]}, 12'b1_0_00000000_0_0);
      end
`ifdef GB_SEQ_STATS_EN
      checks++;
      if (cnt_w[m] !== 16'h0000) begin
        failures++;
        $display("FAIL reset_count dut%0d got=%h want=0000", m, cnt_w[m]);
      end
`endif
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_instr = 8'h8C;
    tick();
    in_valid = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        logic [8:0] want;
        want = (t == 2) ? 9'h18C : 9'h000;
        checks++;
        if ({valid_w[m], instr_w[m]} !== want) begin
          failures++;
          $display("FAIL single_pulse dut%0d t=%0d got=%h want=%h", m, t, {valid_w[m], instr_w[m]}, want);
        end
      end
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (busy_w[m] !== 1'b0) begin
        failures++;
        $display("FAIL single_busy dut%0d got=%b want=0", m, busy_w[m]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 14; t++) begin
      in_valid = (t < 3);
      in_instr = 8'h80 + 8'(t);
      tick();
      for (int m = 0; m < 2; m++) begin
        logic [8:0] want;
        want = 9'h000;
        for (int i = 0; i < 3; i++)
          if (t == 2 + i * (GAPV[m] + 1)) want = {1'b1, 8'h80 + 8'(i)};
        checks++;
        if ({valid_w[m], instr_w[m]} !== want) begin
          failures++;
          $display("FAIL b2b dut%0d t=%0d got=%h want=%h", m, t, {valid_w[m], instr_w[m]}, want);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_halt_fill();
    int acc [2];
    int idx [2];
    in_valid = 1'b1; in_instr = 8'h76;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    for (int m = 0; m < 2; m++) begin
      acc[m] = 0; idx[m] = 0;
      checks++;
      if (halted_w[m] !== 1'b1) begin
        failures++;
        $display("FAIL fill_halted dut%0d got=%b want=1", m, halted_w[m]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_instr = 8'h20 + 8'(i);
      for (int m = 0; m < 2; m++) if (rdy_w[m] === 1'b1) acc[m]++;
      tick();
    end
    in_valid = 1'b0;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (acc[m] != 4 || rdy_w[m] !== 1'b0) begin
        failures++;
        $display("FAIL fill_accepts dut%0d got=%0d/%b want=4/0", m, acc[m], rdy_w[m]);
      end
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        if (valid_w[m] === 1'b1) begin
          checks++;
          if (idx[m] >= 4 || instr_w[m] !== 8'h20 + 8'(idx[m])) begin
            failures++;
            $display("FAIL fill_order dut%0d n=%0d got=%h want=%h", m, idx[m], instr_w[m], 8'h20 + 8'(idx[m]));
          end
          idx[m]++;
        end
      end
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (idx[m] != 4 || halted_w[m] !== 1'b0 || busy_w[m] !== 1'b0) begin
        failures++;
        $display("FAIL fill_drain dut%0d got=%0d/%b/%b want=4/0/0", m, idx[m], halted_w[m], busy_w[m]);
      end
    end
  endtask

  task automatic test_halt_resume();
    int n76 [2];
    int n04 [2];
    int nother [2];
    for (int m = 0; m < 2; m++) begin n76[m] = 0; n04[m] = 0; nother[m] = 0; end
    in_valid = 1'b1; in_instr = 8'h76; tick();
    in_instr = 8'h04; tick();
    in_valid = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      for (int m = 0; m < 2; m++)
        if (valid_w[m] === 1'b1) begin
          if (instr_w[m] === 8'h76) n76[m]++; else nother[m]++;
        end
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (n76[m] != 1 || nother[m] != 0 || halted_w[m] !== 1'b1) begin
        failures++;
        $display("FAIL halt_hold dut%0d got=%0d/%0d/%b want=1/0/1", m, n76[m], nother[m], halted_w[m]);
      end
      nother[m] = 0;
    end
    resume = 1'b1; tick(); resume = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      for (int m = 0; m < 2; m++)
        if (valid_w[m] === 1'b1) begin
          if (instr_w[m] === 8'h04) n04[m]++; else nother[m]++;
        end
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (n04[m] != 1 || nother[m] != 0 || halted_w[m] !== 1'b0) begin
        failures++;
        $display("FAIL halt_resume dut%0d got=%0d/%0d/%b want=1/0/0", m, n04[m], nother[m], halted_w[m]);
      end
    end
  endtask

  task automatic test_reset_mid_gap();
    bit found;
    found = 1'b0;
    for (int t = 0; t < 12 && !found; t++) begin
      in_valid = (t < 5);
      in_instr = 8'hA0 + 8'(t);
      tick();
      if (mst[1] == S_GAP && mq[1].size() == 3) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL midgap_setup got=0 want=1");
    end
    in_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ({valid_w[m], instr_w[m], busy_w[m]} !== 10'h000) begin
        failures++;
        $display("FAIL midgap_reset dut%0d got=%h want=000", m, {valid_w[m], instr_w[m], busy_w[m]});
      end
    end
    for (int t = 0; t < 10; t++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (valid_w[m] !== 1'b0) begin
          failures++;
          $display("FAIL midgap_quiet dut%0d t=%0d got=%b want=0", m, t, valid_w[m]);
        end
      end
    end
  endtask

  task automatic test_random();
    int shown;
    shown = 0;
    for (int t = 0; t < 3000; t++) begin
      in_valid = ($urandom_range(0, 99) < 60);
      in_instr = ($urandom_range(0, 19) == 0) ? 8'h76 : 8'($urandom);
      resume   = ($urandom_range(0, 9) == 0);
      reset    = ($urandom_range(0, 299) == 0);
      tick();
      for (int m = 0; m < 2; m++) begin
        logic [11:0] want;
        want = {mq[m].size() < DEPTH, mvalid[m], minstr[m],
                (mq[m].size() > 0) || (mst[m] != S_IDLE), mst[m] == S_HALT};
        checks++;
        if ({rdy_w[m], valid_w[m], instr_w[m], busy_w[m], halted_w[m]} !== want) begin
          failures++;
          if (shown < 20) begin
            shown++;
            $display("FAIL random dut%0d t=%0d got=%b want=%b", m, t,
                     {rdy_w[m], valid_w[m], instr_w[m], busy_w[m], halted_w[m]}, want);
          end
        end
`ifdef GB_SEQ_STATS_EN
        checks++;
        if (cnt_w[m] !== mcnt[m]) begin
          failures++;
          if (shown < 20) begin
            shown++;
            $display("FAIL random_count dut%0d t=%0d got=%h want=%h", m, t, cnt_w[m], mcnt[m]);
          end
        end
`endif
      end
    end
    reset = 1'b0; resume = 1'b0; in_valid = 1'b0;
  endtask

`ifdef GB_SEQ_STATS_EN
  task automatic test_stats();
    int nxt;
    reset = 1'b1; tick(); reset = 1'b0;
    nxt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (nxt == 8'h76) nxt++;
      if (nxt > 254) break;
      in_valid = 1'b1;
      in_instr = 8'(nxt);
      if (mq[0].size() < DEPTH) nxt++;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 50 && mcnt[0] != 16'd254; i++) tick();
    tick();
    checks++;
    if (cnt_w[0] !== 16'd254) begin
      failures++;
      $display("FAIL stats_sweep got=%0d want=254", cnt_w[0]);
    end
    in_valid = 1'b1; in_instr = 8'h01;
    for (int i = 0; i < 70000 && mcnt[0] != 16'hFFFF; i++) tick();
    checks++;
    if (cnt_w[0] !== 16'hFFFF) begin
      failures++;
      $display("FAIL stats_top got=%h want=ffff", cnt_w[0]);
    end
    for (int i = 0; i < 10 && mcnt[0] != 16'h0000; i++) tick();
    checks++;
    if (cnt_w[0] !== 16'h0000) begin
      failures++;
      $display("FAIL stats_wrap got=%h want=0000", cnt_w[0]);
    end
    in_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_halt_fill();
    test_halt_resume();
    test_reset_mid_gap();
    test_random();
`ifdef GB_SEQ_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
